// File: rtl/serial_alu_sequencer.sv
// Bit-serial sequencer that drives one external 1-bit ALU slice LSB first to build a WIDTH-bit AND/OR/ADD/SUB/SLT.
// Optional build macro SERIAL_ALU_OVF_EN adds the signed-overflow output ovf.
module serial_alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             err,
`ifdef SERIAL_ALU_OVF_EN
    output logic             ovf,
`endif
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_less,
    output logic [2:0]       slice_op,
    input  logic             slice_r,
    input  logic             slice_cout
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SET  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic [IW-1:0]    idx_r;
    logic             carry_r;
    logic             cin_msb_r;
    logic             msb_r;

    logic [WIDTH-1:0] next_result_s;
    logic [IW-1:0]    idx_next_s;
    logic             last_s;
    logic             addsub_s;
    logic             lt_s;

    function automatic logic op_legal(input logic [2:0] o);
        logic ok;
        case (o)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // The slice keeps its native encoding, so SLT is run as a subtract.
    function automatic logic [2:0] slice_code(input logic [2:0] o);
        logic [2:0] c;
        case (o)
            3'b111:  c = 3'b110;
            default: c = o;
        endcase
        return c;
    endfunction

    assign slice_less = 1'b0;

    // Next-state helpers: merged result word, index step, final-bit and SLT decisions.
    always_comb begin
        next_result_s        = result;
        next_result_s[idx_r] = slice_r;
        idx_next_s           = idx_r + IW'(1);
        last_s               = (idx_r == LAST);
        addsub_s             = (op_r == 3'b010) || (op_r == 3'b110);
        lt_s                 = msb_r ^ cin_msb_r ^ carry_r;
    end

    // Sequencer FSM with registered status, result and slice drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= 3'b000;
            idx_r     <= '0;
            carry_r   <= 1'b0;
            cin_msb_r <= 1'b0;
            msb_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            zero      <= 1'b1;
            err       <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            ovf       <= 1'b0;
`endif
            slice_a   <= 1'b0;
            slice_b   <= 1'b0;
            slice_cin <= 1'b0;
            slice_op  <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (op_legal(op)) begin
                            a_r       <= a;
                            b_r       <= b;
                            op_r      <= op;
                            idx_r     <= '0;
                            carry_r   <= op[2];
                            cout      <= 1'b0;
                            err       <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
                            ovf       <= 1'b0;
`endif
                            // Present bit 0 in the first RUN cycle.
                            slice_a   <= a[0];
                            slice_b   <= b[0];
                            slice_cin <= op[2];
                            slice_op  <= slice_code(op);
                            state_r   <= RUN;
                        end else begin
                            result  <= '0;
                            zero    <= 1'b1;
                            err     <= 1'b1;
                            cout    <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
                            ovf     <= 1'b0;
`endif
                            done    <= 1'b1;
                            state_r <= FIN;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    result  <= next_result_s;
                    carry_r <= slice_cout;
                    if (last_s) begin
                        cin_msb_r <= carry_r;
                        msb_r     <= slice_r;
                        slice_a   <= 1'b0;
                        slice_b   <= 1'b0;
                        slice_cin <= 1'b0;
                        slice_op  <= 3'b000;
                        if (op_r == 3'b111) begin
                            state_r <= SET;
                        end else begin
                            cout    <= addsub_s ? slice_cout : 1'b0;
                            zero    <= (next_result_s == '0);
`ifdef SERIAL_ALU_OVF_EN
                            ovf     <= addsub_s ? (carry_r ^ slice_cout) : 1'b0;
`endif
                            done    <= 1'b1;
                            state_r <= FIN;
                        end
                    end else begin
                        idx_r     <= idx_next_s;
                        slice_a   <= a_r[idx_next_s];
                        slice_b   <= b_r[idx_next_s];
                        slice_cin <= slice_cout;
                    end
                end
                SET: begin
                    // Signed less-than is sign bit corrected by overflow.
                    result  <= {{(WIDTH-1){1'b0}}, lt_s};
                    zero    <= ~lt_s;
                    cout    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= FIN;
                end
                FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Table-driven, scoreboarded bench for serial_alu_sequencer with a behavioural 1-bit slice model.
module tb_serial_alu_sequencer;

    localparam int W = 32;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         e;
        logic         v;
        int           lat;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         err;
`ifdef SERIAL_ALU_OVF_EN
    logic         ovf;
`endif
    logic         slice_a;
    logic         slice_b;
    logic         slice_cin;
    logic         slice_less;
    logic [2:0]   slice_op;
    logic         slice_r;
    logic         slice_cout;
    logic         sbb;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t exp_q[$];
    vec_t vt[$];

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero), .err(err),
`ifdef SERIAL_ALU_OVF_EN
        .ovf(ovf),
`endif
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin), .slice_less(slice_less),
        .slice_op(slice_op), .slice_r(slice_r), .slice_cout(slice_cout)
    );

    // External slice: op[2] inverts b, op[1:0] selects AND/OR/SUM.
    assign sbb        = slice_b ^ slice_op[2];
    assign slice_r    = slice_op[1] ? (slice_a ^ sbb ^ slice_cin)
                                    : (slice_op[0] ? (slice_a | sbb) : (slice_a & sbb));
    assign slice_cout = (slice_a & sbb) | (slice_a & slice_cin) | (sbb & slice_cin);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic int lat_of(input logic [2:0] o);
        case (o)
            3'b000, 3'b001, 3'b010, 3'b110: return W + 1;
            3'b111:                         return W + 2;
            default:                        return 1;
        endcase
    endfunction

    function automatic vec_t lit(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [W-1:0] r, input logic c, input logic z,
                                 input logic e, input logic v);
        vec_t t;
        t.op = o; t.a = x; t.b = y; t.r = r; t.c = c; t.z = z; t.e = e; t.v = v;
        t.lat = lat_of(o);
        return t;
    endfunction

    function automatic vec_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        vec_t t;
        logic [W:0] s;
        t.op = o; t.a = x; t.b = y; t.r = '0; t.c = 1'b0; t.e = 1'b0; t.v = 1'b0;
        t.lat = lat_of(o);
        case (o)
            3'b000: t.r = x & y;
            3'b001: t.r = x | y;
            3'b010: begin
                s = {1'b0, x} + {1'b0, y};
                t.r = s[W-1:0]; t.c = s[W];
                t.v = (x[W-1] == y[W-1]) && (t.r[W-1] != x[W-1]);
            end
            3'b110: begin
                s = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
                t.r = s[W-1:0]; t.c = s[W];
                t.v = (x[W-1] != y[W-1]) && (t.r[W-1] != x[W-1]);
            end
            3'b111: t.r = {{(W-1){1'b0}}, ($signed(x) < $signed(y))};
            default: t.e = 1'b1;
        endcase
        t.z = (t.r == '0);
        return t;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_ctrl"}, {busy, done, cout, err, zero}, 5'b00001);
        check({tag, "_result"}, result, '0);
        check({tag, "_slice"}, {slice_a, slice_b, slice_cin, slice_less, slice_op}, 7'd0);
`ifdef SERIAL_ALU_OVF_EN
        check({tag, "_ovf"}, ovf, 1'b0);
`endif
    endtask

    // Drive one operation, follow the slice sequence, and score the done outputs.
    task automatic run_op(input vec_t v, input int inj_at, input int rst_at, input bit b2b);
        vec_t       e;
        logic       c;
        logic       bb;
        logic [2:0] sop;
        int         cyc;
        bit         seen;
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        exp_q.push_back(v);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        check("busy_accept", busy, 1'b1);
        c   = v.op[2];
        sop = (v.op == 3'b111) ? 3'b110 : v.op;
        while (!done && cyc < W + 4) begin
            if (!v.e && cyc < W) begin
                check("slice_seq", {slice_a, slice_b, slice_cin, slice_less, slice_op},
                      {v.a[cyc], v.b[cyc], c, 1'b0, sop});
                bb = v.b[cyc] ^ v.op[2];
                c  = (v.a[cyc] & bb) | (v.a[cyc] & c) | (bb & c);
            end
            start = (cyc == inj_at);
            if (cyc == inj_at) begin
                op = 3'b001; a = '1; b = '1;
            end
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                check_reset_values("rst_mid");
                e = exp_q.pop_front();
                @(posedge clk); #1;
                @(negedge clk);
                rst = 1'b0;
                seen = 1'b0;
                repeat (W + 4) begin
                    @(posedge clk); #1;
                    seen = seen | done;
                end
                check("no_done_after_rst", seen, 1'b0);
                return;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done, 1'b1);
        e = exp_q.pop_front();
        if (done) begin
            check("latency", cyc + 1, v.lat);
            check("result", result, e.r);
            check("cout", cout, e.c);
            check("zero", zero, e.z);
            check("err", err, e.e);
`ifdef SERIAL_ALU_OVF_EN
            check("ovf", ovf, e.v);
`endif
            check("slice_idle", {slice_a, slice_b, slice_cin, slice_less, slice_op}, 7'd0);
        end
        if (b2b) begin
            start = 1'b1; op = 3'b010; a = 32'd5; b = 32'd7;
        end
        @(posedge clk); #1;
        check("done_pulse", {done, busy}, 2'b00);
        if (inj_at >= 0) begin
            seen = 1'b0;
            repeat (W + 4) begin
                @(posedge clk); #1;
                seen = seen | busy | done;
            end
            check("no_queue", seen, 1'b0);
            check("result_held", result, e.r);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
        vt.push_back(lit(3'b010, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1'b0, 1'b0));
        vt.push_back(lit(3'b110, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0));
        vt.push_back(lit(3'b110, 32'd9,        32'd9,        32'd0,        1'b1, 1'b1, 1'b0, 1'b0));
        vt.push_back(lit(3'b111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0, 1'b0));
        vt.push_back(lit(3'b111, 32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0));
        vt.push_back(lit(3'b111, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0));
        vt.push_back(lit(3'b010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(lit(3'b000, 32'hF0F0A5A5, 32'hFF00FF00, 32'hF000A500, 1'b0, 1'b0, 1'b0, 1'b0));
        vt.push_back(lit(3'b010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b1, 1'b0, 1'b0));
        vt.push_back(lit(3'b001, 32'hF0F0A5A5, 32'hFF00FF00, 32'hFFF0FFA5, 1'b0, 1'b0, 1'b0, 1'b0));
        vt.push_back(lit(3'b011, 32'h12345678, 32'h1,        32'd0,        1'b0, 1'b1, 1'b1, 1'b0));
        vt.push_back(lit(3'b110, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1));
        vt.push_back(lit(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b1, 1'b1, 1'b0));
        vt.push_back(lit(3'b111, 32'd7,        32'd5,        32'd0,        1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 6; i++) begin
            logic [2:0] ops [5];
            ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
            vt.push_back(model(ops[$urandom_range(4, 0)], $urandom, $urandom));
        end

        @(posedge clk); #1;
        check_reset_values("rst_init");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            run_op(vt[i], -1, -1, 1'b0);
        end

        run_op(model(3'b010, 32'h12345678, 32'h11111111), 10, -1, 1'b0);
        run_op(model(3'b110, 32'hDEADBEEF, 32'h01234567), -1, 16, 1'b0);
        run_op(model(3'b010, 32'd5, 32'd7), -1, -1, 1'b0);
        run_op(model(3'b001, 32'h0000FFFF, 32'h00FF0000), -1, -1, 1'b1);
        run_op(model(3'b010, 32'd5, 32'd7), -1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
